// File: rtl/tdm_demux16_if.sv
// Serial beat stream feeding the 16-channel TDM demultiplexer.
// The master drives one W-bit beat per slot; sync marks slot 0.
// There is no backpressure, so the stream carries no ready signal.
interface tdm_demux16_if #(
    parameter int W = 4
);
    logic [W-1:0] din;
    logic         din_valid;
    logic         sync;

    modport master (
        output din,
        output din_valid,
        output sync
    );

    modport slave (
        input din,
        input din_valid,
        input sync
    );
endinterface

// File: rtl/tdm_demux16.sv
// tdm_demux16: 1-to-16 time-division demultiplexer for W-bit channels.
// Beats arriving on the slave stream are steered into 16 live channel
// registers under control of a slot counter and a HUNT/RUN FSM.  When the
// slot-15 beat is written, a frame-coherent copy of all channels is
// published on frame_data together with a one-cycle frame_done pulse.
//
// Optional build macro TDM_DEMUX_SYNC_CHECK_EN adds a sync_err output and
// makes a missing sync at slot 0 drop the beat and fall back to HUNT.
// Without the macro, a missing sync at slot 0 is accepted as channel 0.
module tdm_demux16 #(
    parameter int W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    tdm_demux16_if.slave    bus,
    output logic [16*W-1:0] ch_data,
    output logic [15:0]     ch_strobe,
    output logic [16*W-1:0] frame_data,
    output logic            frame_done,
    output logic [3:0]      slot,
    output logic            locked
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    ,
    output logic            sync_err
`endif
);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;

    // Per-beat actions decoded from the current state and input stream.
    logic       wr_en;      // write din into channel wr_idx this edge
    logic [3:0] wr_idx;     // channel selected for the write
    logic [3:0] slot_nxt;   // slot counter value after this edge
    logic       frame_end;  // this write completes a frame (slot 15)
    logic       miss;       // unsynced beat at slot 0 while in RUN, dropped
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    logic       err;        // sync arrived out of place, or was missing
`endif

    // FSM state register; reset returns the receiver to hunting for sync.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: lock on the first synced beat, and when sync
    // checking is built in, lose lock on a missing slot-0 marker.
    always_comb begin
        state_nxt = state;
        case (state)
            HUNT: begin
                if (bus.din_valid && bus.sync) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
                if (bus.din_valid && !bus.sync && (slot == 4'd0)) begin
                    state_nxt = HUNT;
                end
`endif
            end
            default: state_nxt = HUNT;
        endcase
    end

    // FSM outputs: decode which channel (if any) this beat lands in and
    // where the slot counter goes next.  A synced beat always realigns to
    // channel 0, abandoning any partial frame without touching frame_data.
    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = 4'd0;
        slot_nxt  = slot;
        frame_end = 1'b0;
        miss      = 1'b0;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
        err       = 1'b0;
`endif
        if (bus.din_valid) begin
            if (bus.sync) begin
                wr_en    = 1'b1;
                wr_idx   = 4'd0;
                slot_nxt = 4'd1;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
                err      = (state == RUN) && (slot != 4'd0);
`endif
            end else if (state == RUN) begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
                miss = (slot == 4'd0);
                err  = miss;
`endif
                if (!miss) begin
                    wr_en     = 1'b1;
                    wr_idx    = slot;
                    slot_nxt  = slot + 4'd1;
                    frame_end = (slot == 4'd15);
                end
            end
        end
    end

    assign locked = (state == RUN);

    // Channel registers, strobes, slot counter and frame snapshot.  The
    // snapshot takes the incoming slot-15 beat directly from the stream so
    // that it is coherent with the live registers in the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_data    <= '0;
            ch_strobe  <= '0;
            frame_data <= '0;
            frame_done <= 1'b0;
            slot       <= 4'd0;
        end else begin
            ch_strobe  <= wr_en ? (16'd1 << wr_idx) : 16'd0;
            frame_done <= frame_end;
            slot       <= slot_nxt;
            if (wr_en) begin
                ch_data[wr_idx*W +: W] <= bus.din;
            end
            if (frame_end) begin
                frame_data <= {bus.din, ch_data[15*W-1:0]};
            end
        end
    end

`ifdef TDM_DEMUX_SYNC_CHECK_EN
    // One-cycle alignment error flag, aligned with the strobe outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_err <= 1'b0;
        end else begin
            sync_err <= err;
        end
    end
`endif

endmodule

// File: doc/tdm_demux16.md
Name: tdm_demux16

Overview:
- 1-to-16 time-division demultiplexer for 4-bit channels; the receive-side counterpart of the 16:1 channel mux.
- Accepts a serial stream of W-bit beats, one per slot, with a sync marker on slot 0.
- Steers each beat into one of 16 per-channel registers, using a slot counter and a hunt/run FSM.
- Publishes a frame-coherent snapshot of all 16 channels once slot 15 is written.

Parameters:
- W, 4, channel data width in bits; the channel count is fixed at 16.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- din  input  W  beat data for the current slot.
- din_valid  input  1  beat present this cycle; no backpressure, every valid beat is consumed.
- sync  input  1  qualifies din as slot 0; ignored when din_valid=0.
- ch_data  output  16*W  live channel registers; channel k occupies bits [k*W+W-1 : k*W].
- ch_strobe  output  16  one-hot; bit k high for one cycle after channel k is written.
- frame_data  output  16*W  snapshot of all channels, updated atomically at frame end.
- frame_done  output  1  one-cycle pulse when frame_data updates.
- slot  output  4  index of the next slot expected.
- locked  output  1  FSM is in RUN.

Behaviour:
- Reset (rst_n=0 sampled on a rising edge):
  - ch_data, frame_data, ch_strobe, frame_done, slot and locked are all 0.
  - FSM enters HUNT.
  - Reset mid-frame discards the partial frame.
- FSM state HUNT:
  - Beats without sync are dropped; no strobe.
  - din_valid && sync: write din to ch0, pulse ch_strobe[0], slot<=1, go to RUN.
- FSM state RUN, on din_valid && sync:
  - Realign: write ch0, slot<=1, pulse ch_strobe[0].
  - The partial frame is abandoned; frame_data is unchanged.
- FSM state RUN, on din_valid && !sync:
  - Write ch[slot], pulse ch_strobe[slot], slot<=slot+1 (4-bit wrap 15->0).
  - At slot 0 with no sync, the beat is accepted as ch0 (free-run).
- Cycles with din_valid=0: no state change, all strobes low.
- Latency: ch_data, ch_strobe and slot reflect a beat in the cycle after it is sampled (1 cycle).
- Frame completion (beat written to slot 15):
  - In the same edge, frame_data loads all 15 held channels plus the incoming slot-15 beat.
  - frame_done pulses in the same cycle as ch_strobe[15].
- frame_data holds between completions; a partial frame never reaches it.
- Back-to-back valid beats are sustained at 1 beat/cycle indefinitely.

Optional Feature:
- Macro TDM_DEMUX_SYNC_CHECK_EN.
- When defined:
  - Adds output sync_err (1 bit, reset 0).
  - sync_err pulses one cycle if, in RUN, sync arrives with slot!=0. The realign still happens as above.
  - sync_err also pulses if, in RUN, a valid beat without sync arrives at slot 0. That beat is dropped, slot stays 0, and the FSM returns to HUNT with locked<=0.
- When undefined:
  - No sync_err port.
  - Missing sync at slot 0 is tolerated (free-run).

Test Plan:
- Reset with rst_n=0 for 2 cycles and garbage on din/din_valid -> all outputs 0, locked=0, slot=0.
- In HUNT, 3 valid beats with sync=0, then sync=1 with din=0xA -> first 3 beats ignored; ch0=0xA, ch_strobe=0x0001, slot=1, locked=1.
- Full frame, din=k for slot k (0..15), back-to-back:
  - frame_done pulses exactly once with ch_strobe[15].
  - frame_data equals 0xFEDCBA9876543210.
  - slot returns to 0.
- Second frame with din=15-k and din_valid gapped every other cycle -> frame_data becomes 0x0123456789ABCDEF only after the slot-15 beat; it is unchanged before that.
- Mid-frame sync at slot 7 (din=0x5) -> ch0=0x5, slot=1, no frame_done, frame_data unchanged; with TDM_DEMUX_SYNC_CHECK_EN, sync_err=1 for one cycle.
- Reset asserted at slot 9, then a new frame -> partial data discarded, HUNT re-entered, next full frame completes normally; with TDM_DEMUX_SYNC_CHECK_EN, a no-sync beat at slot 0 gives sync_err=1 and locked=0.
